// File: rtl/wave_pwm_dac_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : wave_pwm_dac_if                                          |
// | Description : Sample/observe bundle between the waveform generator    |
// |               and the PWM DAC stage. The master drives the run enable, |
// |               the attenuation select and the sample. The slave (the   |
// |               DAC) returns the PWM bit, the period strobe and the      |
// |               latched duty value.                                      |
// | Revision    : 1.0  initial release                                     |
// +-----------------------------------------------------------------------+
interface wave_pwm_dac_if #(
   parameter int WIDTH = 8
);
   logic             en;
   logic [1:0]       amp_sel;
   logic [WIDTH-1:0] wave;
   logic             pwm_out;
   logic             period_done;
   logic [WIDTH-1:0] duty;

   modport master (
      output en,
      output amp_sel,
      output wave,
      input  pwm_out,
      input  period_done,
      input  duty
   );

   modport slave (
      input  en,
      input  amp_sel,
      input  wave,
      output pwm_out,
      output period_done,
      output duty
   );
endinterface
`default_nettype wire

// File: rtl/wave_pwm_dac.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : wave_pwm_dac                                             |
// | Description : Converts the 8-bit waveform generator sample stream     |
// |               into a 1-bit PWM output. The sample is resampled once    |
// |               per 2^WIDTH-cycle period, attenuated by a power of two   |
// |               and compared against a free-running counter. A one-cycle |
// |               strobe marks the last cycle of each period.              |
// |               Optional build macro PWM_SIGMA_DELTA_EN replaces the     |
// |               comparator with a first-order sigma-delta modulator.     |
// | Revision    : 1.0  initial release                                     |
// +-----------------------------------------------------------------------+
module wave_pwm_dac #(
   parameter int WIDTH = 8
) (
   input  wire logic          clk,
   input  wire logic          rst,
   wave_pwm_dac_if.slave      bus_if
);

   // Terminal count and the value one cycle before it. The strobe register
   // is loaded on the edge where the counter reaches the terminal count, so
   // it is decoded from the value just before.
   localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] CNT_PRE = CNT_MAX - {{(WIDTH-1){1'b0}}, 1'b1};

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;
   logic [WIDTH-1:0] duty_q;
   logic [WIDTH-1:0] duty_d;
   logic             pwm_q;
   logic             pwm_d;
   logic             pd_q;
   logic             pd_d;

   // ---------------------------------------------------------------------
   // Shared decode
   // ---------------------------------------------------------------------
   logic             w_wrap;
   logic             w_load;
   logic [WIDTH-1:0] w_scaled;

   // The wrap edge is the only point inside a running period where a new
   // sample may be taken. While idle the duty register follows the input
   // so the first period after enable starts from a fresh sample.
   assign w_wrap   = bus_if.en & (cnt_q == CNT_MAX);
   assign w_load   = w_wrap | ~bus_if.en;
   assign w_scaled = bus_if.wave >> bus_if.amp_sel;

   // Period counter, duty capture and period strobe next-state.
   always_comb begin
      cnt_d  = '0;
      duty_d = duty_q;
      pd_d   = 1'b0;

      if (bus_if.en) begin
         cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
         pd_d  = (cnt_q == CNT_PRE);
      end

      if (w_load) begin
         duty_d = w_scaled;
      end
   end

   // Period counter, duty and strobe registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         duty_q <= '0;
         pd_q   <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         duty_q <= duty_d;
         pd_q   <= pd_d;
      end
   end

`ifdef PWM_SIGMA_DELTA_EN
   // ---------------------------------------------------------------------
   // Sigma-delta modulator: the low WIDTH bits carry the running residue,
   // the top bit is the carry out of the last addition and becomes the
   // output bit on the following edge. Over any 2^WIDTH-cycle window with a
   // constant duty D this yields exactly D ones, evenly spread.
   // ---------------------------------------------------------------------
   logic [WIDTH:0] acc_q;
   logic [WIDTH:0] acc_d;

   // Accumulator and output bit next-state; held at zero while idle.
   always_comb begin
      acc_d = '0;
      pwm_d = 1'b0;
      if (bus_if.en) begin
         acc_d = {1'b0, acc_q[WIDTH-1:0]} + {1'b0, duty_q};
         pwm_d = acc_q[WIDTH];
      end
   end

   // Accumulator register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end
`else
   // ---------------------------------------------------------------------
   // Comparator PWM: high for the first duty_q counts of each period. A
   // full-scale duty of 2^WIDTH-1 leaves one low cycle; 100% is not
   // reachable by design.
   // ---------------------------------------------------------------------

   // Output bit next-state from the counter/duty comparison.
   always_comb begin
      pwm_d = 1'b0;
      if (bus_if.en) begin
         pwm_d = (cnt_q < duty_q);
      end
   end
`endif

   // Registered output bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm_q <= 1'b0;
      end else begin
         pwm_q <= pwm_d;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign bus_if.pwm_out     = pwm_q;
   assign bus_if.period_done = pd_q;
   assign bus_if.duty        = duty_q;

endmodule
`default_nettype wire

// File: tb/tb_wave_pwm_dac.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : tb_wave_pwm_dac                                          |
// | Description : Self-checking bench for wave_pwm_dac. A behavioural      |
// |               reference built from the period/duty rules predicts      |
// |               every output cycle; window counts check the per-period   |
// |               high time and strobe rate. Honours PWM_SIGMA_DELTA_EN.   |
// | Revision    : 1.0  initial release                                     |
// +-----------------------------------------------------------------------+
module tb_wave_pwm_dac;

   localparam int W      = 8;
   localparam int PERIOD = 1 << W;

   logic clk;
   logic rst;

   wave_pwm_dac_if #(.WIDTH(W)) bus_if ();

   wave_pwm_dac #(.WIDTH(W)) u_dut (
      .clk    (clk),
      .rst    (rst),
      .bus_if (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int errors  = 0;

   // Reference state: position within the period, latched duty, outputs.
   int m_pos  = 0;
   int m_duty = 0;
   int m_pwm  = 0;
   int m_pd   = 0;
   int m_acc  = 0;

   // Window statistics.
   int hi_cnt   = 0;
   int pd_cnt   = 0;
   int adj_cnt  = 0;
   int prev_pwm = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int attenuate(input int w, input int a);
      return w / (2 ** a);
   endfunction

   // One clock: advance the reference at the edge, then compare 1 time unit later.
   task automatic step();
      int n_pos, n_duty, n_pwm, n_pd, n_acc;
      bit run;
      @(posedge clk);
      if (rst) begin
         n_pos = 0; n_duty = 0; n_pwm = 0; n_pd = 0; n_acc = 0;
      end else begin
         run    = (bus_if.en === 1'b1);
         n_pos  = run ? (m_pos + 1) % PERIOD : 0;
         n_pd   = (run && m_pos == PERIOD - 2) ? 1 : 0;
         n_duty = (!run || m_pos == PERIOD - 1) ? attenuate(int'(bus_if.wave), int'(bus_if.amp_sel)) : m_duty;
`ifdef PWM_SIGMA_DELTA_EN
         n_pwm  = (run && m_acc >= PERIOD) ? 1 : 0;
         n_acc  = run ? (m_acc % PERIOD) + m_duty : 0;
`else
         n_pwm  = (run && m_pos < m_duty) ? 1 : 0;
         n_acc  = 0;
`endif
      end
      m_pos = n_pos; m_duty = n_duty; m_pwm = n_pwm; m_pd = n_pd; m_acc = n_acc;
      #1;
      check("pwm_out", {31'd0, bus_if.pwm_out}, m_pwm);
      check("period_done", {31'd0, bus_if.period_done}, m_pd);
      check("duty", {24'd0, bus_if.duty}, m_duty);
      if (bus_if.pwm_out === 1'b1) hi_cnt++;
      if (bus_if.period_done === 1'b1) pd_cnt++;
      if (bus_if.pwm_out === 1'b1 && prev_pwm == 1) adj_cnt++;
      prev_pwm = (bus_if.pwm_out === 1'b1) ? 1 : 0;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic clear_stats();
      hi_cnt = 0; pd_cnt = 0; adj_cnt = 0;
   endtask

   // Idle one cycle to load the sample, enable, let one period settle, then
   // measure a full window of steady-state output.
   task automatic run_window(input int wv, input int am, input string tag);
      int d;
      d = attenuate(wv, am);
      bus_if.en      = 1'b0;
      bus_if.wave    = wv[W-1:0];
      bus_if.amp_sel = am[1:0];
      step();
      bus_if.en = 1'b1;
      steps(PERIOD);
      clear_stats();
      steps(PERIOD);
      check({tag, "_high"}, hi_cnt, d);
      check({tag, "_strobes"}, pd_cnt, 1);
`ifdef PWM_SIGMA_DELTA_EN
      if (d <= PERIOD / 2) check({tag, "_adjacent"}, adj_cnt, 0);
`endif
   endtask

   initial begin
      int guard;
      rst            = 1'b1;
      bus_if.en      = 1'b0;
      bus_if.amp_sel = 2'd0;
      bus_if.wave    = 8'hA5;

      // Reset state, then idle tracking of the sample.
      steps(3);
      check("reset_pwm", {31'd0, bus_if.pwm_out}, 0);
      check("reset_duty", {24'd0, bus_if.duty}, 0);
      rst = 1'b0;
      steps(4);
      check("idle_duty_a5", {24'd0, bus_if.duty}, 32'hA5);
      for (int i = 0; i < 8; i++) begin
         bus_if.wave = W'($urandom_range(0, PERIOD - 1));
         step();
      end

      // Basic PWM and boundaries.
      run_window(64, 0, "basic64");
      run_window(0, 0, "zero");
      run_window(255, 0, "full");
      run_window(64, 0, "again64");

      // Attenuation with a mid-period sample change.
      bus_if.en = 1'b0; bus_if.wave = 8'd200; bus_if.amp_sel = 2'd2;
      step();
      check("atten_duty", {24'd0, bus_if.duty}, 50);
      bus_if.en = 1'b1;
      clear_stats();
      for (int i = 0; i < PERIOD; i++) begin
         step();
         if (m_pos == 100) bus_if.wave = 8'd10;
      end
`ifndef PWM_SIGMA_DELTA_EN
      check("atten_first_period", hi_cnt, 50);
`endif
      clear_stats();
      steps(PERIOD);
`ifndef PWM_SIGMA_DELTA_EN
      check("atten_next_period", hi_cnt, 2);
`endif
      check("atten_strobes", pd_cnt, 1);

      // Abort mid-period: no strobe while idle, then a full period follows.
      bus_if.amp_sel = 2'd0; bus_if.wave = 8'd128;
      guard = 0;
      while (m_pos != 30 && guard < 2 * PERIOD) begin
         step();
         guard++;
      end
      check("abort_reach_30", m_pos, 30);
      bus_if.en = 1'b0;
      step();
      check("abort_pwm_low", {31'd0, bus_if.pwm_out}, 0);
      clear_stats();
      steps(PERIOD + 40);
      check("abort_no_strobe", pd_cnt, 0);
      run_window(128, 0, "reenable");

      // Asynchronous reset mid-period.
      steps(77);
      #2 rst = 1'b1;
      #1;
      check("async_pwm", {31'd0, bus_if.pwm_out}, 0);
      check("async_pd", {31'd0, bus_if.period_done}, 0);
      check("async_duty", {24'd0, bus_if.duty}, 0);
      m_pos = 0; m_duty = 0; m_pwm = 0; m_pd = 0; m_acc = 0;
      steps(2);
      rst = 1'b0;
      clear_stats();
      steps(PERIOD);
      check("post_reset_strobes", pd_cnt, 1);

      // Random windows with constant settings.
      for (int k = 0; k < 3; k++) begin
         run_window(int'($urandom_range(0, PERIOD - 1)), int'($urandom_range(0, 3)), "rand_window");
      end

      // Random stress: sample, attenuation and enable changes at any time.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) bus_if.wave = W'($urandom_range(0, PERIOD - 1));
         if ($urandom_range(0, 15) == 0) bus_if.amp_sel = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 199) == 0) bus_if.en = ~bus_if.en;
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/wave_pwm_dac.md
Name: wave_pwm_dac

Overview:
- Downstream stage of the 8-bit waveform generator.
- Consumes the generator's parallel `wave` sample stream and converts it into a 1-bit pulse-width-modulated output, which drives the board's RC low-pass / scope pin.
- Resamples the input once per PWM period and applies a selectable power-of-two amplitude attenuation.
- Emits a period strobe that upstream logic can use to pace sample updates.

Parameters:
- WIDTH, 8, sample width and PWM counter width; PWM period = 2^WIDTH clk cycles.

Ports:
- clk  input  1  system clock (same clock as the waveform generator).
- rst  input  1  asynchronous, active-high reset.
- en  input  1  run enable; low = idle/hold.
- amp_sel  input  2  attenuation: 0 = x1, 1 = x1/2, 2 = x1/4, 3 = x1/8.
- wave  input  WIDTH  unsigned sample from the waveform generator.
- pwm_out  output  1  registered PWM (or sigma-delta) bit.
- period_done  output  1  one-cycle strobe on the last cycle of each period.
- duty  output  WIDTH  currently latched duty value (debug/observe).

Behaviour:
- Reset (async, rst=1): cnt=0, duty=0, acc=0, pwm_out=0, period_done=0. Reset is honoured at any point mid-period; the next period after release starts at cnt=0.
- cnt:
  - WIDTH-bit up-counter.
  - While en=1: increments every clk and wraps 2^WIDTH-1 -> 0.
  - While en=0: forced to 0.
- Duty load:
  - Value loaded is `wave >> amp_sel` (logical shift, zero-fill; no rounding).
  - Loaded on the clk edge where en=1 and cnt==2^WIDTH-1, i.e. at the wrap.
  - Also loaded every clk while en=0, so the first period after enable uses a fresh sample.
  - Both wave and amp_sel are sampled at that same edge; mid-period changes are ignored.
- period_done:
  - Registered; high for exactly one clk, the cycle after the edge where cnt reaches 2^WIDTH-1 (aligned with cnt==2^WIDTH-1).
  - Always 0 while en=0.
- PWM mode (default):
  - pwm_out <= en & (cnt < duty), registered, so 1 clk latency relative to cnt.
  - High time per period = duty cycles.
  - duty=0 gives a constant 0.
  - duty=2^WIDTH-1 gives high for 255 of 256 cycles at WIDTH=8; 100% is unreachable by design.
- Enable transitions:
  - en falling mid-period: the period aborts immediately; pwm_out goes 0 on the next edge; no period_done is issued.
  - en rising: the period starts at cnt=0 using the duty loaded during idle.
- Simultaneous wave change and wrap edge: the value present at that edge is the one captured.

Optional Feature:
- Macro: PWM_SIGMA_DELTA_EN.
- When defined:
  - pwm_out is driven by a first-order sigma-delta modulator instead of the comparator.
  - A (WIDTH+1)-bit accumulator runs `acc <= {1'b0, acc[WIDTH-1:0]} + duty` every clk while en=1, and pwm_out <= en & acc[WIDTH] (the carry).
  - acc is cleared by rst and held at 0 while en=0.
  - cnt, duty loading and period_done behave exactly as in PWM mode.
  - For a constant duty D, each 2^WIDTH-cycle window contains exactly D ones, spread rather than grouped.
- When undefined: the accumulator logic is absent and comparator PWM is used.

Test Plan:
- Reset/idle: rst=1, then release with en=0 and wave=8'hA5 -> pwm_out=0, period_done=0, duty tracks 8'hA5 every cycle, cnt stays 0.
- Basic PWM: en=1, amp_sel=0, wave=64 held -> each 256-cycle period has exactly 64 consecutive high cycles starting 1 clk after cnt=0; period_done pulses once every 256 clk.
- Boundaries: wave=0 -> pwm_out never high; wave=255 -> 255 high cycles and 1 low cycle per period.
- Attenuation + mid-period change: wave=200 with amp_sel=2 -> duty=50. Change wave to 10 at cnt=100 -> current period keeps 50 high cycles, next period has 2 (10>>2).
- Abort/async reset: deassert en at cnt=30 -> pwm_out=0 next clk and no period_done. Re-enable -> a full period follows. Assert rst mid-period -> all outputs 0 immediately, without waiting for a clk edge.
- Sigma-delta (PWM_SIGMA_DELTA_EN defined): wave=64, en=1 -> exactly 64 ones per 256-cycle window, never two ones adjacent; period_done timing is identical to PWM mode.
